// File: rtl/keypad_pkg.sv
// Shared helpers for the keypad scanner: code width, key encoding
// and lowest-set-bit priority encoding.
package keypad_pkg;

   function automatic int key_w(input int n);
      int w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   function automatic int encode(input int row, input int col,
                                 input int cols);
      return row * cols + col;
   endfunction

   function automatic int lowest(input logic [63:0] v);
      int idx = 0;
      for (int i = 63; i >= 0; i--)
         if (v[i]) idx = i;
      return idx;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-matrix debouncer: commits a sweep after DEBOUNCE+1 identical
// sweeps and reports the lowest newly pressed key of that commit.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int N        = 16,
   parameter int DEBOUNCE = 2,
   parameter int KEY_W    = 4
) (
   input  logic             scan_clk,
   input  logic             rst_n,
   input  logic [N-1:0]     sweep,
   input  logic             strobe,
   output logic [N-1:0]     committed,
   output logic             press,
   output logic [KEY_W-1:0] press_code
);

   logic [N-1:0] prev;
   logic [N-1:0] fresh;
   logic [3:0]   stable;
   logic [3:0]   stable_nx;
   logic         commit;

   always_comb begin
      stable_nx = stable;
      if (strobe) begin
         if (sweep != prev)
            stable_nx = '0;
         else if (stable != 4'(DEBOUNCE))
            stable_nx = stable + 4'd1;
      end
   end

   // releases update committed but never raise press
   assign fresh      = sweep & ~committed;
   assign commit     = strobe && (stable_nx == 4'(DEBOUNCE))
                       && (sweep != committed);
   assign press      = commit && (|fresh);
   assign press_code = KEY_W'(lowest(64'(fresh)));

   always_ff @(posedge scan_clk) begin
      if (!rst_n) begin
         prev      <= '0;
         stable    <= '0;
         committed <= '0;
      end else begin
         stable <= stable_nx;
         if (strobe) prev <= sweep;
         if (commit) committed <= sweep;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Active-low ROWS x COLS keypad scanner with row synchroniser,
// whole-matrix debounce and a valid/ready press-event register.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int SCAN_DIV = 4,
   parameter int DEBOUNCE = 2,
   parameter int KEY_W    = key_w(ROWS * COLS)
) (
   input  logic             scan_clk,
   input  logic             rst_n,
   input  logic [ROWS-1:0]  row_n,
   output logic [COLS-1:0]  col_n,
   output logic             keydown,
   output logic [KEY_W-1:0] key,
   output logic             multi,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [KEY_W-1:0] evt_code,
   output logic             overrun
);

   localparam int N  = ROWS * COLS;
   localparam int CW = $clog2(COLS);
   localparam int DW = $clog2(SCAN_DIV);

   logic [ROWS-1:0]  sync1;
   logic [ROWS-1:0]  row_s;
   logic             run;
   logic [CW-1:0]    col;
   logic [CW-1:0]    col_nx;
   logic [DW-1:0]    dwell;
   logic [DW-1:0]    dwell_nx;
   logic             last_dwell;
   logic             last_col;
   logic             sweep_end;
   logic [N-1:0]     sweep;
   logic [N-1:0]     sweep_d;
   logic [N-1:0]     committed;
   logic             press;
   logic [KEY_W-1:0] press_code;

   assign last_dwell = dwell == DW'(SCAN_DIV - 1);
   assign last_col   = col == CW'(COLS - 1);
   assign sweep_end  = last_dwell && last_col;

   // run holds the counters still for the first cycle out of reset
   always_comb begin
      col_nx   = col;
      dwell_nx = dwell;
      if (run) begin
         if (last_dwell) begin
            dwell_nx = '0;
            col_nx   = last_col ? '0 : col + 1'b1;
         end else begin
            dwell_nx = dwell + 1'b1;
         end
      end
   end

   always_comb begin
      sweep_d = sweep;
      if (last_dwell)
         for (int r = 0; r < ROWS; r++)
            sweep_d[KEY_W'(encode(r, int'(col), COLS))] = ~row_s[r];
   end

   always_ff @(posedge scan_clk) begin
      if (!rst_n) begin
         sync1 <= '1;
         row_s <= '1;
         run   <= 1'b0;
         col   <= '0;
         dwell <= '0;
         col_n <= '1;
         sweep <= '0;
      end else begin
         sync1 <= row_n;
         row_s <= sync1;
         run   <= 1'b1;
         col   <= col_nx;
         dwell <= dwell_nx;
         col_n <= ~(COLS'(1) << col_nx);
         sweep <= sweep_d;
      end
   end

   keypad_debounce #(
      .N        (N),
      .DEBOUNCE (DEBOUNCE),
      .KEY_W    (KEY_W)
   ) u_debounce (
      .scan_clk   (scan_clk),
      .rst_n      (rst_n),
      .sweep      (sweep_d),
      .strobe     (sweep_end),
      .committed  (committed),
      .press      (press),
      .press_code (press_code)
   );

   assign keydown = |committed;
   assign key     = KEY_W'(lowest(64'(committed)));
   assign multi   = (committed & (committed - N'(1))) != '0;

   always_ff @(posedge scan_clk) begin
      if (!rst_n) begin
         evt_valid <= 1'b0;
         evt_code  <= '0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (press) begin
            if (evt_valid && !evt_ready) begin
               overrun <= 1'b1;
            end else begin
               evt_valid <= 1'b1;
               evt_code  <= press_code;
            end
         end else if (evt_ready) begin
            evt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus random key sets
// checked sweep by sweep against a history-based reference model.
module tb_keypad_scanner;

   logic       scan_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       evt_ready = 1'b0;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic       keydown;
   logic [3:0] key;
   logic       multi;
   logic       evt_valid;
   logic [3:0] evt_code;
   logic       overrun;

   logic [15:0] keys = '0;
   int nchk = 0;
   int nerr = 0;

   logic [15:0] hist[$];
   logic [15:0] m_comm;
   logic        m_pend;
   logic [3:0]  m_code;

   always #5 scan_clk = ~scan_clk;

   keypad_scanner dut (
      .scan_clk  (scan_clk),
      .rst_n     (rst_n),
      .row_n     (row_n),
      .col_n     (col_n),
      .keydown   (keydown),
      .key       (key),
      .multi     (multi),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_code  (evt_code),
      .overrun   (overrun)
   );

   // a closed key shorts its row to its column
   always_comb begin
      row_n = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
   end

   function automatic int low_idx(input logic [15:0] v);
      int r = 0;
      for (int i = 15; i >= 0; i--)
         if (v[i]) r = i;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge scan_clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      evt_ready = 1'b0;
      tick();
      chk("rst_col_n", col_n, 32'hf);
      chk("rst_keydown", keydown, 0);
      chk("rst_key", key, 0);
      chk("rst_multi", multi, 0);
      chk("rst_evt_valid", evt_valid, 0);
      chk("rst_evt_code", evt_code, 0);
      chk("rst_overrun", overrun, 0);
      rst_n = 1'b1;
      tick();
      hist   = {16'h0};
      m_comm = '0;
      m_pend = 1'b0;
      m_code = '0;
   endtask

   // mode 0: ready low, 1: ready high all sweep, 2: ready only at sweep end
   task automatic run_sweep(input int mode);
      logic        ov_mid = 1'b0;
      logic        exp_ov = 1'b0;
      logic [15:0] s;
      logic [15:0] fresh;
      evt_ready = (mode == 1);
      for (int i = 0; i < 16; i++) begin
         if (i == 15 && mode == 2) evt_ready = 1'b1;
         tick();
         if (i < 15) ov_mid |= overrun;
      end
      s = keys;
      if (mode == 1) m_pend = 1'b0;
      hist.push_back(s);
      if (hist.size() > 3) void'(hist.pop_front());
      fresh = '0;
      if (hist.size() == 3 && hist[0] == s && hist[1] == s
          && s != m_comm) begin
         fresh  = s & ~m_comm;
         m_comm = s;
      end
      if (fresh != 0) begin
         if (m_pend && mode == 0) begin
            exp_ov = 1'b1;
         end else begin
            m_pend = 1'b1;
            m_code = 4'(low_idx(fresh));
         end
      end else if (mode != 0) begin
         m_pend = 1'b0;
      end
      chk("evt_valid", evt_valid, m_pend);
      chk("evt_code", evt_code, m_code);
      chk("keydown", keydown, m_comm != 0);
      chk("key", key, low_idx(m_comm));
      chk("multi", multi, $countones(m_comm) > 1);
      chk("overrun", overrun, exp_ov);
      chk("overrun_width", ov_mid, 0);
   endtask

   initial begin
      logic [3:0] ec;
      logic       pv;
      int         ov_cnt;
      int         rises;
      int         k;
      int         mode;

      // 1: column walk and idle outputs
      do_reset();
      for (int i = 0; i < 16; i++) begin
         ec = 4'b0001;
         ec = ~(ec << (i / 4));
         chk("s1_col_n", col_n, ec);
         chk("s1_idle", {keydown, multi, evt_valid, overrun}, 0);
         tick();
      end
      hist.push_back(16'h0);
      chk("s1_wrap", col_n, 32'he);
      run_sweep(1);
      run_sweep(1);

      // 2: key (2,1) held from reset, then released
      keys = 16'h0200;
      do_reset();
      repeat (3) run_sweep(0);
      chk("s2_valid", evt_valid, 1);
      chk("s2_code", evt_code, 9);
      chk("s2_key", key, 9);
      keys = '0;
      repeat (3) run_sweep(1);
      chk("s2_release", keydown, 0);

      // 3: bouncing (0,3) then held
      keys = '0;
      do_reset();
      ov_cnt = 0;
      rises = 0;
      for (int i = 0; i < 160; i++) begin
         keys[3] = (i < 100) ? ((i / 10) % 2 == 0) : 1'b1;
         pv = evt_valid;
         tick();
         if (overrun) ov_cnt++;
         if (evt_valid && !pv) rises++;
      end
      chk("s3_valid", evt_valid, 1);
      chk("s3_code", evt_code, 3);
      chk("s3_key", key, 3);
      chk("s3_events", rises, 1);
      chk("s3_overrun", ov_cnt, 0);

      // 4: ready low, press 5 then 12
      keys = '0;
      do_reset();
      keys = 16'h0020;
      repeat (3) run_sweep(0);
      chk("s4_first", evt_code, 5);
      keys = 16'h1020;
      repeat (3) run_sweep(0);
      chk("s4_code", evt_code, 5);
      chk("s4_multi", multi, 1);
      chk("s4_key", key, 5);

      // 5: new commit of 12 coincides with acceptance of 5
      keys = 16'h0020;
      repeat (3) run_sweep(0);
      keys = 16'h1020;
      run_sweep(0);
      run_sweep(0);
      run_sweep(2);
      chk("s5_code", evt_code, 12);
      chk("s5_valid", evt_valid, 1);
      chk("s5_overrun", overrun, 0);

      // 6: reset mid-sweep with key 7 pending
      keys = 16'h0080;
      do_reset();
      repeat (3) run_sweep(0);
      chk("s6_pending", evt_valid, 1);
      repeat (7) tick();
      do_reset();
      repeat (3) run_sweep(0);
      chk("s6_code", evt_code, 7);
      chk("s6_valid", evt_valid, 1);

      // random key sets and ready modes
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            keys = '0;
            k = $urandom_range(0, 2);
            repeat (k) keys[$urandom_range(0, 15)] = 1'b1;
         end
         mode = $urandom_range(0, 2);
         run_sweep(mode);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
